// File: rtl/mmio_param_fifo.sv
// Parametrised synchronous FIFO behind the AFU MMIO user registers.
// Provides first-word fall-through, occupancy and status, synchronous flush, and sticky error flags.
module mmio_param_fifo #(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AF_THRESH = DEPTH - 1,
    parameter int unsigned CW        = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] q_o,
    input  logic             flush_i,
    input  logic             clr_err_i,
    output logic             full_o,
    output logic             empty_o,
    output logic             almost_full_o,
    output logic [CW-1:0]    count_o,
    output logic             overflow_o,
    output logic             underflow_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wp_q, wp_d;
    logic [PW-1:0]    rp_q, rp_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic full, empty;
    logic push_ok, pop_ok, push_rej, pop_rej;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Flush masks both requests, so nothing is stored and no error is raised.
    assign push_ok  = ~flush_i & push_i & (~full | pop_i);
    assign pop_ok   = ~flush_i & pop_i & ~empty;
    assign push_rej = ~flush_i & push_i & full & ~pop_i;
    assign pop_rej  = ~flush_i & pop_i & empty;

    always_comb begin
        wp_d        = wp_q;
        rp_d        = rp_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (flush_i) begin
            wp_d    = '0;
            rp_d    = '0;
            count_d = '0;
        end else begin
            if (push_ok) begin
                wp_d = (wp_q == PW'(DEPTH - 1)) ? '0 : wp_q + 1'b1;
            end
            if (pop_ok) begin
                rp_d = (rp_q == PW'(DEPTH - 1)) ? '0 : rp_q + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count_d = count_q + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count_d = count_q - 1'b1;
            end
        end

        // A rejected request in the same cycle as clr_err leaves the flag set.
        if (clr_err_i) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (push_rej) begin
            overflow_d = 1'b1;
        end
        if (pop_rej) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wp_q        <= '0;
            rp_q        <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_ok) begin
            mem_q[wp_q] <= d_i;
        end
    end

    always_comb begin
        q_o           = empty ? '0 : mem_q[rp_q];
        full_o        = full;
        empty_o       = empty;
        almost_full_o = (count_q >= CW'(AF_THRESH));
        count_o       = count_q;
        overflow_o    = overflow_q;
        underflow_o   = underflow_q;
    end

endmodule

// File: tb/tb_mmio_param_fifo.sv
// Directed self-checking bench for mmio_param_fifo (DEPTH=4, AF_THRESH=3, WIDTH=8).
module tb_mmio_param_fifo;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AFT   = 3;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             push, pop, flush, clr_err;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             full, empty, almost_full, overflow, underflow;
    logic [CW-1:0]    count;

    int vectors    = 0;
    int miscompares = 0;

    mmio_param_fifo #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AF_THRESH(AFT)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .push_i       (push),
        .d_i          (d),
        .pop_i        (pop),
        .q_o          (q),
        .flush_i      (flush),
        .clr_err_i    (clr_err),
        .full_o       (full),
        .empty_o      (empty),
        .almost_full_o(almost_full),
        .count_o      (count),
        .overflow_o   (overflow),
        .underflow_o  (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_pop [4];

    initial begin
        rst_n = 1'b0; push = 1'b0; pop = 1'b0; flush = 1'b0; clr_err = 1'b0; d = '0;
        exp_pop[0] = 8'hA1; exp_pop[1] = 8'hA2; exp_pop[2] = 8'hA3; exp_pop[3] = 8'hB0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_q", 32'(q), 32'd0);
        chk("rst_af", 32'(almost_full), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_udf", 32'(underflow), 32'd0);

        // Fill A0..A3
        for (int i = 0; i < 4; i++) begin
            push = 1'b1; d = 8'hA0 + 8'(i);
            tick();
            chk("fill_count", 32'(count), 32'(i + 1));
            chk("fill_af", 32'(almost_full), (i + 1 >= 3) ? 32'd1 : 32'd0);
            chk("fill_full", 32'(full), (i == 3) ? 32'd1 : 32'd0);
            chk("fill_q", 32'(q), 32'hA0);
        end
        push = 1'b0;

        // Rejected push on full
        push = 1'b1; d = 8'hFF;
        tick();
        push = 1'b0;
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd4);
        chk("ovf_q", 32'(q), 32'hA0);

        // Push+pop while full
        push = 1'b1; pop = 1'b1; d = 8'hB0;
        chk("pp_full_head", 32'(q), 32'hA0);
        tick();
        push = 1'b0; pop = 1'b0;
        chk("pp_full_q", 32'(q), 32'hA1);
        chk("pp_full_count", 32'(count), 32'd4);

        for (int i = 0; i < 4; i++) begin
            chk("drain_q", 32'(q), 32'(exp_pop[i]));
            pop = 1'b1;
            tick();
        end
        pop = 1'b0;
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_q0", 32'(q), 32'd0);
        chk("drain_udf", 32'(underflow), 32'd0);

        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("clr_ovf", 32'(overflow), 32'd0);

        // Wrap-around: 10 push/pop pairs
        for (int i = 1; i <= 10; i++) begin
            push = 1'b1; d = 8'(i);
            tick();
            push = 1'b0;
            chk("wrap_count1", 32'(count), 32'd1);
            chk("wrap_q", 32'(q), 32'(i));
            pop = 1'b1;
            tick();
            pop = 1'b0;
            chk("wrap_count0", 32'(count), 32'd0);
        end

        // Push+pop on empty
        push = 1'b1; pop = 1'b1; d = 8'h55;
        tick();
        push = 1'b0; pop = 1'b0;
        chk("ppe_udf", 32'(underflow), 32'd1);
        chk("ppe_count", 32'(count), 32'd1);
        chk("ppe_q", 32'(q), 32'h55);
        chk("ppe_ovf", 32'(overflow), 32'd0);
        pop = 1'b1;
        tick();
        chk("ppe_pop_empty", 32'(empty), 32'd1);
        clr_err = 1'b1;
        tick();
        pop = 1'b0;
        chk("clr_vs_udf", 32'(underflow), 32'd1);
        tick();
        clr_err = 1'b0;
        chk("clr_udf", 32'(underflow), 32'd0);

        // Flush with underflow set and three entries held
        pop = 1'b1;
        tick();
        pop = 1'b0;
        chk("pre_flush_udf", 32'(underflow), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            push = 1'b1; d = 8'(i);
            tick();
        end
        chk("pre_flush_count", 32'(count), 32'd3);
        flush = 1'b1; d = 8'h77;
        tick();
        flush = 1'b0; push = 1'b0;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_empty", 32'(empty), 32'd1);
        chk("flush_q", 32'(q), 32'd0);
        chk("flush_udf", 32'(underflow), 32'd1);
        chk("flush_ovf", 32'(overflow), 32'd0);
        push = 1'b1; d = 8'h88;
        tick();
        push = 1'b0;
        chk("post_flush_q", 32'(q), 32'h88);
        chk("post_flush_count", 32'(count), 32'd1);

        // Asynchronous reset mid-burst
        push = 1'b1; d = 8'h99;
        tick();
        tick();
        chk("burst_count", 32'(count), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_q", 32'(q), 32'd0);
        chk("arst_udf", 32'(underflow), 32'd0);
        chk("arst_af", 32'(almost_full), 32'd0);
        push = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst_release_empty", 32'(empty), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mmio_param_fifo.md
# mmio_param_fifo

Parametrised synchronous FIFO that replaces the fixed single-register shift FIFO behind the AFU's MMIO user registers. It has separate push/pop handshakes, configurable width and depth, full/empty/almost-full status, an occupancy count, a synchronous flush, and sticky overflow/underflow error flags. The flags let host software detect MMIO writes to a full queue and reads from an empty queue. It sits between the CCI-P MMIO write/read decode logic and the user datapath.

## Interface
- WIDTH, 64, data word width in bits (>= 1)
- DEPTH, 16, number of entries; any value >= 2, not required to be a power of two
- AF_THRESH, DEPTH-1, almost_full asserts when count >= AF_THRESH (1..DEPTH)
- CW, $clog2(DEPTH+1), width of count (derived, not overridden)

- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- push  in  1  write request; d is captured when the push is accepted
- d  in  WIDTH  write data
- pop  in  1  read request; removes the head entry when accepted
- q  out  WIDTH  head entry (first-word fall-through); all zeros when empty
- flush  in  1  synchronous clear of contents
- clr_err  in  1  clears the sticky error flags
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_THRESH
- count  out  CW  current occupancy, 0..DEPTH
- overflow  out  1  sticky: a push was rejected
- underflow  out  1  sticky: a pop was rejected

## Operation
- Storage is a circular buffer of DEPTH registers with a write pointer (wp) and a read pointer (rp).
- Each pointer increments on its accepted operation and wraps from DEPTH-1 to 0.
- count is a registered up/down counter; full, empty and almost_full are decoded from the registered count.
- Accepted push (push_ok) = push & (!full | pop). Rejected push = push & full & !pop.
- Accepted pop (pop_ok) = pop & !empty. Rejected pop = pop & empty.
- Push and pop together while full: both are accepted, count is unchanged, and the head is replaced by the next entry.
- Push and pop together while empty: the push is accepted, the pop is rejected (underflow is set), and count becomes 1.
- Push and pop together otherwise: both are accepted and count is unchanged.
- count next value: +1 if push_ok only, -1 if pop_ok only, otherwise unchanged.
- Flush has priority over push and pop in the same cycle:
  - wp, rp and count go to 0; storage contents need not be cleared.
  - Push/pop in the flush cycle are ignored and raise no error flags.
  - Error flags keep their values through a flush.
- Error flags:
  - overflow is set on any rejected push; underflow is set on any rejected pop.
  - Both are cleared by clr_err.
  - If a rejected event and clr_err occur in the same cycle, the flag is set (the event wins).
- q is mem[rp] driven combinationally from the storage registers, forced to 0 when empty.

## Timing
- Reset (rst_n low, asynchronous): wp = rp = 0, count = 0, empty = 1, full = 0, almost_full = 0, overflow = 0, underflow = 0, q = 0. Storage registers are reset to 0.
- Push accepted at edge N: count, empty and full update after edge N. Data is visible on q after edge N if the FIFO was empty (one-cycle write-to-read latency).
- Pop accepted at edge N: q shows the next entry after edge N. The popped value must be sampled before edge N (a consumer reads q while it asserts pop).
- Error flags assert the cycle after the offending request.
- No combinational path from push or pop to full, empty, count or q.
- Reset asserted mid-operation discards all contents and flags immediately, without waiting for a clock edge.

## Test plan
- Reset, then idle -> empty=1, full=0, count=0, q=0, overflow=0, underflow=0.
- DEPTH=4, AF_THRESH=3; push 0xA0..0xA3 on consecutive cycles -> count reaches 1,2,3,4; almost_full goes high when count=3; full goes high when count=4; q=0xA0 from the cycle after the first push.
- Full FIFO; push 0xFF alone -> rejected, overflow=1, count=4. Then push 0xB0 with pop together -> q becomes 0xA1, count stays 4. After four pops the values read are 0xA1, 0xA2, 0xA3, 0xB0 and empty=1.
- Wrap-around: 10 interleaved push/pop pairs of 0x1..0xA on an empty FIFO -> every value is popped in order, count never exceeds 1, and wp/rp wrap through index 0.
- Empty FIFO; push 0x55 with pop together -> underflow=1, count=1, q=0x55. Then clr_err together with a pop on the now-empty FIFO -> underflow stays 1. Then clr_err alone -> underflow=0.
- 3 entries held; flush together with push 0x77 -> count=0, empty=1, q=0, 0x77 is not stored, overflow/underflow unchanged. Assert rst_n low asynchronously mid-burst -> all outputs return to their reset values before the next clock edge.
